// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared definitions for the byte-serial wide adder.
//   BYTE_W           : width of the shared adder slice
//   wide_add_state_t : controller states
//   idx_width()      : width of the byte index for a given operand size
package wide_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wide_add_state_t;

    // A 1-byte operand still needs a 1-bit index.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: operand/result handshake bundle for wide_add_seq.
//   Upstream  : in_valid/in_ready, a, b, cin (and sub when WIDE_ADD_SUB_EN)
//   Downstream: out_valid/out_ready, sum, cout
//   Status    : busy
// Modports: slave = the adder block, master = the producer/consumer side.
// Optional macro: WIDE_ADD_SUB_EN adds the sub request line.
interface wide_add_seq_if #(
    parameter int NBYTES = 4
);
    import wide_add_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [NBYTES*BYTE_W-1:0]   a;
    logic [NBYTES*BYTE_W-1:0]   b;
    logic                       cin;
`ifdef WIDE_ADD_SUB_EN
    logic                       sub;
`endif
    logic                       out_valid;
    logic                       out_ready;
    logic [NBYTES*BYTE_W-1:0]   sum;
    logic                       cout;
    logic                       busy;

    modport slave (
        input  in_valid, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
        output in_valid, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/wide_add_seq_byte_adder.sv
// byte_adder: combinational 8-bit carry-lookahead adder.
//   a, b : byte operands
//   ci   : carry in
//   s    : byte sum
//   co   : carry out
// Every carry is formed directly from generate/propagate terms and ci,
// so no carry depends on a lower carry output.
module byte_adder
    import wide_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci
    always_comb begin : lookahead
        logic pp;
        c  = '0;
        pp = 1'b0;
        c[0] = ci;
        for (int i = 0; i < BYTE_W; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
    end

    assign s  = p ^ c[BYTE_W-1:0];
    assign co = c[BYTE_W];

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: NBYTES*8-bit adder built from one shared 8-bit adder,
// processing one byte per cycle, LSB first, with the carry held in a register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : in_valid/in_ready + a, b, cin (+ sub) upstream;
//                out_valid/out_ready + sum, cout downstream; busy status
// Optional macro: WIDE_ADD_SUB_EN -- sub=1 at accept computes a - b
// (captures ~b, forces carry-in to 1; cout = 1 means no borrow).
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wide_add_seq_if.slave bus
);

    localparam int                IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NBYTES - 1);

    wide_add_state_t state, state_nxt;

    logic [NBYTES-1:0][BYTE_W-1:0] a_reg;
    logic [NBYTES-1:0][BYTE_W-1:0] b_reg;
    logic [NBYTES-1:0][BYTE_W-1:0] sum_reg;
    logic [IDX_W-1:0]              idx;
    logic                          carry_reg;
    logic                          cout_reg;

    logic                          accept;
    logic [NBYTES*BYTE_W-1:0]      b_cap;
    logic                          cin_eff;
    logic [BYTE_W-1:0]             add_s;
    logic                          add_co;

    assign accept = (state == IDLE) && bus.in_valid;

`ifdef WIDE_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_cap   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_cap   = bus.b;
    assign cin_eff = bus.cin;
`endif

    byte_adder u_byte_adder (
        .a  (a_reg[idx]),
        .b  (b_reg[idx]),
        .ci (carry_reg),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs depend on state only, so no input reaches an output
    // combinationally.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= b_cap;
            carry_reg <= cin_eff;
            idx       <= '0;
        end else if (state == RUN) begin
            // Unwritten upper bytes keep stale data until their cycle comes.
            sum_reg[idx] <= add_s;
            carry_reg    <= add_co;
            if (idx == LAST) begin
                cout_reg <= add_co;
                idx      <= '0;
            end else begin
                idx      <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: self-checking bench for wide_add_seq (NBYTES = 4).
// Directed scenarios plus randomized transactions with random output stalls,
// all compared against whole-word arithmetic computed in the bench.
// Optional macro: WIDE_ADD_SUB_EN enables subtract scenarios.
module tb_wide_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wide_add_seq_if #(.NBYTES(NB)) bus ();

    wide_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-word model: {cout, sum} of a +/- b.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sb);
        logic [W:0] r;
        if (sb) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return r;
    endfunction

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sb);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef WIDE_ADD_SUB_EN
        bus.sub = sb;
`else
        if (sb) bus.cin = cin;
`endif
    endtask

    // One transaction; stall = number of DONE cycles held with out_ready low.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sb, input int stall, input string tag);
        logic [W:0] exp;
        int k;
        exp = ref_add(a, b, cin, sb);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        drive_ops(a, b, cin, sb);
        @(negedge clk);
        // Scramble operands after accept; they must be ignored.
        bus.in_valid = 1'b0;
        drive_ops($urandom, $urandom, 1'($urandom), 1'($urandom));
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_no_ready_run"}, 64'(bus.in_ready), 64'd0);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(NB));
        check({tag, "_sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
        check({tag, "_cout"}, 64'(bus.cout), 64'(exp[W]));
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b1;
            drive_ops($urandom, $urandom, 1'($urandom), 1'($urandom));
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
            check({tag, "_hold_cout"}, 64'(bus.cout), 64'(exp[W]));
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        if (stall > 0) begin
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            check({tag, "_taken"}, 64'(bus.out_valid), 64'd0);
            check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
            check({tag, "_no_accept"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sb;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_ops('0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        rst_n = 1'b1;

        run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, "carry1");
        run_txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, "ripple");
        run_txn(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 5, "stall5");

        // Reset during the second RUN cycle.
        @(negedge clk);
        bus.in_valid = 1'b1;
        drive_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_sum", 64'(bus.sum), 64'd0);
        check("mid_rst_cout", 64'(bus.cout), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, "after_rst");

        // Back-to-back: second accept one cycle after the first handshake.
        run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, "b2b_a");
        run_txn(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, "b2b_b");

`ifdef WIDE_ADD_SUB_EN
        run_txn(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, "sub_borrow");
        run_txn(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, "sub_noborrow");
        run_txn(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 0, "sub0_add");
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef WIDE_ADD_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_txn($urandom, $urandom, 1'($urandom), sb, int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle controller that performs NBYTES×8-bit addition by sequencing a single shared 8-bit adder one byte per cycle, least-significant byte first. Carry is chained between bytes in a register. It sits between an upstream operand producer and a downstream result consumer, with a valid/ready handshake on each side. This trades latency for area wherever a wide adder is not affordable.

## Interface
- NBYTES, 4: operand width in bytes; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  8*NBYTES  operand A.
- b  input  8*NBYTES  operand B.
- cin  input  1  carry-in to byte 0.
- sub  input  1  subtract request; present only with WIDE_ADD_SUB_EN.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  8*NBYTES  registered result.
- cout  output  1  carry out of the top byte.
- busy  output  1  high in RUN.

## Operation
- States:
  - IDLE: in_ready = 1.
  - RUN: processes one byte per cycle.
  - DONE: out_valid = 1.
- IDLE→RUN on in_valid & in_ready.
  - a, b, and the effective carry-in are captured into internal registers.
  - Byte index idx is cleared to 0.
  - Input changes after the accept are ignored.
- In RUN, each cycle:
  - Byte idx of a_reg and b_reg, plus carry_reg, drive the byte adder.
  - The 8-bit sum is written to sum[8*idx +: 8] and the adder carry to carry_reg.
  - idx increments.
- RUN→DONE on the cycle that processes idx = NBYTES-1. cout = final carry.
- DONE→IDLE on out_valid & out_ready. sum and cout hold their values until the next accept overwrites them.
- in_valid is ignored outside IDLE. There is no overlap of transactions.
- idx width is max(1, $clog2(NBYTES)). idx never exceeds NBYTES-1.
- sum bytes not yet written in RUN keep their previous values. Only DONE qualifies sum.
- Arithmetic is unsigned modulo 2^(8*NBYTES); the carry beyond the top byte appears only on cout.

## Timing
- Reset (rst_n low at a clk edge), from any state including mid-RUN:
  - state = IDLE, idx = 0, carry_reg = 0.
  - sum = 0, cout = 0, out_valid = 0, busy = 0, in_ready = 1.
- Accept at edge T. Bytes are processed at edges T+1 through T+NBYTES. out_valid rises after edge T+NBYTES.
- Latency from accept to out_valid is NBYTES cycles.
- Throughput: at most one transaction per NBYTES+2 cycles with out_ready tied high. The IDLE cycle after DONE is mandatory.
- Backpressure: while out_valid & !out_ready, sum, cout, and out_valid are stable, and in_ready = 0.
- in_ready, out_valid, and busy are decoded from registered state only, with no combinational input-to-output path.
- NBYTES = 1: RUN lasts exactly one cycle.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - sub port exists.
  - On accept with sub = 1, ~b is captured and the effective carry-in is 1; cin is ignored.
  - cout then means "no borrow" (1 when a ≥ b).
  - With sub = 0, behaviour is identical to the macro being undefined.
- WIDE_ADD_SUB_EN undefined: no sub port. The block performs addition only, with the effective carry-in = cin.

## Structure
- Package wide_add_pkg:
  - BYTE_W = 8.
  - State enum typedef wide_add_state_t {IDLE, RUN, DONE}.
- Sub-module byte_adder: combinational 8-bit carry-lookahead adder.
  - Inputs: a[7:0], b[7:0], ci.
  - Outputs: s[7:0], co.
  - Exactly one instance, driven through idx-selected byte muxes.
- Top level holds the FSM, operand registers, idx counter, carry_reg, and sum register.

## Test plan
All scenarios use NBYTES = 4.
- a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0; out_valid exactly 4 cycles after accept.
- a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1; the carry ripples through all four bytes.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid → out_valid, sum, and cout stable; in_ready=0; no new accept; result taken on the first out_ready=1.
- Assert rst_n=0 for one edge during the second RUN cycle → next cycle state IDLE, busy=0, out_valid=0, sum=0, in_ready=1. A following add of 0x12345678+0x11111111 yields 0x23456789.
- Back-to-back with out_ready=1: 0x12345678+0x11111111, then 0x80000000+0x80000000 → 0x23456789/cout=0, then 0x00000000/cout=1; the second accept occurs one cycle after the first output handshake.
- With WIDE_ADD_SUB_EN:
  - a=0x00000005, b=0x00000007, sub=1 → sum=0xFFFFFFFE, cout=0.
  - a=7, b=5, sub=1 → sum=0x00000002, cout=1.
